// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock first-word-fall-through FIFO with level, almost flags and flush.
// Optional sticky overflow/underflow flags are built when SYNC_FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_fwft #(
   parameter int DATA_WIDTH    = 25,
   parameter int ADDR_WIDTH    = 9,
   parameter int AFULL_THRESH  = 2**ADDR_WIDTH-4,
   parameter int AEMPTY_THRESH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_en,
   output logic                  wr_full,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   input  logic                  rd_en,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] FULL_LVL = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AF_LVL   = (ADDR_WIDTH+1)'(AFULL_THRESH);
   localparam logic [ADDR_WIDTH:0] AE_LVL   = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] head_q;
   logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d, ram_cnt;
   logic                  valid_q, valid_d, push, pop, refill;

   // Accepted push/pop decode and next-state of pointers, level and head-valid; flush clears them.
   always_comb begin
      ram_cnt  = wr_ptr_q - rd_ptr_q;
      push     = wr_en && !wr_full;
      pop      = rd_en && valid_q;
      refill   = (!valid_q || pop) && (ram_cnt != '0);
      wr_ptr_d = flush ? '0 : wr_ptr_q + (ADDR_WIDTH+1)'(push);
      rd_ptr_d = flush ? '0 : rd_ptr_q + (ADDR_WIDTH+1)'(refill);
      level_d  = flush ? '0 : level_q + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop);
      valid_d  = flush ? 1'b0 : (refill ? 1'b1 : (pop ? 1'b0 : valid_q));
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         valid_q  <= valid_d;
      end
   end

   // Storage write port; contents survive reset so this maps cleanly onto block RAM.
   always_ff @(posedge clk) begin
      if (push && !flush && !reset) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
   end

   // Registered RAM read into the head register; holds its value when not refilled.
   always_ff @(posedge clk) begin
      if (reset) head_q <= '0;
      else if (refill && !flush) head_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
   end

   assign rd_data      = head_q;
   assign rd_valid     = valid_q;
   assign level        = level_q;
   assign wr_full      = level_q == FULL_LVL;
   assign almost_full  = level_q >= AF_LVL;
   assign almost_empty = level_q <= AE_LVL;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
   logic ovf_q, unf_q;
   // Sticky error flags; only reset clears them, flush leaves them alone.
   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_q | (wr_en & wr_full);
         unf_q <= unf_q | (rd_en & ~valid_q);
      end
   end
   assign overflow  = ovf_q;
   assign underflow = unf_q;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// tb_sync_fifo_fwft: directed plus random stimulus against a queue-based reference model.
module tb_sync_fifo_fwft;
   logic       clk = 1'b0, reset = 1'b0, flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
   logic [7:0] wr_data = '0, rd_data;
   logic       wr_full, rd_valid, almost_full, almost_empty, overflow, underflow;
   logic [2:0] level;
   int         nvec = 0, nerr = 0;

   logic [7:0] mq[$];
   bit         mvalid, movf, munf;
   logic [7:0] mdata;

   sync_fifo_fwft #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AFULL_THRESH(3), .AEMPTY_THRESH(1)) dut (
      .clk(clk), .reset(reset), .flush(flush), .wr_data(wr_data), .wr_en(wr_en),
      .wr_full(wr_full), .rd_data(rd_data), .rd_valid(rd_valid), .rd_en(rd_en),
      .level(level), .almost_full(almost_full), .almost_empty(almost_empty),
      .overflow(overflow), .underflow(underflow));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("rd_data", 32'(rd_data), 32'(mdata));
      check("rd_valid", 32'(rd_valid), 32'(mvalid));
      check("level", 32'(level), 32'(mq.size()));
      check("wr_full", 32'(wr_full), 32'(mq.size() == 4));
      check("almost_full", 32'(almost_full), 32'(mq.size() >= 3));
      check("almost_empty", 32'(almost_empty), 32'(mq.size() <= 1));
      check("overflow", 32'(overflow), 32'(movf));
      check("underflow", 32'(underflow), 32'(munf));
   endtask

   task automatic model_edge(input logic we, input logic [7:0] wd, input logic re, input logic fl);
      bit full, pop;
      int ramc;
      full = mq.size() == 4;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      movf |= we && full;
      munf |= re && !mvalid;
`endif
      if (fl) begin
         mq.delete();
         mvalid = 0;
      end else begin
         pop  = re && mvalid;
         ramc = mq.size() - int'(mvalid);
         if (pop) void'(mq.pop_front());
         if ((!mvalid || pop) && ramc > 0) begin
            mvalid = 1;
            mdata  = mq[0];
         end else if (pop) mvalid = 0;
         if (we && !full) mq.push_back(wd);
      end
   endtask

   task automatic step(input logic we, input logic [7:0] wd, input logic re, input logic fl);
      wr_en = we; wr_data = wd; rd_en = re; flush = fl;
      model_edge(we, wd, re, fl);
      @(posedge clk); #1;
      check_all();
   endtask

   task automatic do_reset();
      reset = 1; wr_en = 0; rd_en = 0; flush = 0;
      mq.delete(); mvalid = 0; mdata = '0; movf = 0; munf = 0;
      @(posedge clk); #1;
      reset = 0;
      check_all();
   endtask

   initial begin
      do_reset();
      // single word fall-through
      step(1, 8'hA5, 0, 0);
      check("a5_level", 32'(level), 1);
      check("a5_valid_early", 32'(rd_valid), 0);
      step(0, 0, 0, 0);
      check("a5_valid", 32'(rd_valid), 1);
      check("a5_data", 32'(rd_data), 32'hA5);
      step(0, 0, 1, 0);
      check("a5_pop_valid", 32'(rd_valid), 0);
      check("a5_pop_level", 32'(level), 0);
      // fill, overflow attempt, drain in order
      for (int i = 1; i <= 4; i++) step(1, 8'(i), 0, 0);
      check("fill_full", 32'(wr_full), 1);
      check("fill_afull", 32'(almost_full), 1);
      step(1, 8'h05, 0, 0);
      check("drop_level", 32'(level), 4);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      check("ovf_set", 32'(overflow), 1);
`else
      check("ovf_off", 32'(overflow), 0);
`endif
      for (int i = 1; i <= 4; i++) begin
         check("order_data", 32'(rd_data), 32'(i));
         step(0, 0, 1, 0);
      end
      check("drained", 32'(rd_valid), 0);
      // simultaneous push/pop when full and mid-level
      for (int i = 0; i < 4; i++) step(1, 8'(8'h10 + i), 0, 0);
      step(0, 0, 0, 0);
      step(1, 8'h20, 1, 0);
      check("full_pushpop_level", 32'(level), 3);
      step(0, 0, 1, 0);
      step(1, 8'h21, 1, 0);
      check("mid_pushpop_level", 32'(level), 2);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
      // streaming with rd_en held high, pointers wrap several times
      for (int i = 0; i < 20; i++) step(1, 8'($urandom), 1, 0);
      check("stream_valid", 32'(rd_valid), 1);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
      // flush with a concurrent write, then underflow, then reset clears it
      do_reset();
      for (int i = 0; i < 3; i++) step(1, 8'(8'h30 + i), 0, 0);
      step(1, 8'h77, 0, 1);
      check("flush_level", 32'(level), 0);
      check("flush_valid", 32'(rd_valid), 0);
      check("flush_aempty", 32'(almost_empty), 1);
      step(0, 0, 1, 0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      check("unf_set", 32'(underflow), 1);
`endif
      do_reset();
      check("unf_cleared", 32'(underflow), 0);
      // random traffic
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 31) == 0));
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/sync_fifo_fwft.md
# sync_fifo_fwft

Parametrised single-clock FIFO with first-word-fall-through output, occupancy count, programmable almost-full/almost-empty thresholds and a synchronous flush. It buffers producer-to-consumer streams within one clock domain, such as queued memory writes, UART/SPI byte streams and GPU command words. The storage array maps to block RAM. An output register presents the head word without a read request.

## Interface
- DATA_WIDTH, 25: word width in bits.
- ADDR_WIDTH, 9: storage address width; DEPTH = 2**ADDR_WIDTH words.
- AFULL_THRESH, 2**ADDR_WIDTH-4: almost_full asserts when level >= this; legal 1..DEPTH.
- AEMPTY_THRESH, 4: almost_empty asserts when level <= this; legal 0..DEPTH-1.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of contents; otherwise behaves as an ordinary input.
- wr_data  input  DATA_WIDTH  word to push.
- wr_en  input  1  push request.
- wr_full  output  1  high when level == DEPTH.
- rd_data  output  DATA_WIDTH  head word; valid when rd_valid.
- rd_valid  output  1  head word present.
- rd_en  input  1  pop (acknowledge) of the current head word.
- level  output  ADDR_WIDTH+1  words accepted and not yet popped, 0..DEPTH.
- almost_full  output  1  level >= AFULL_THRESH.
- almost_empty  output  1  level <= AEMPTY_THRESH.
- overflow  output  1  sticky; only with SYNC_FIFO_ERR_FLAGS_EN.
- underflow  output  1  sticky; only with SYNC_FIFO_ERR_FLAGS_EN.

## Operation
- Storage: RAM array of DEPTH words, plus a one-word output register (head).
- Pointers are ADDR_WIDTH+1 bits and wrap modulo 2*DEPTH; RAM is indexed by the low ADDR_WIDTH bits.
- Accepted push: wr_en && !wr_full. The word is written at wr_ptr, wr_ptr increments and level increments.
- A push while wr_full is dropped. No state changes except the overflow flag.
- Accepted pop: rd_en && rd_valid, and level decrements. rd_en while !rd_valid is ignored except for the underflow flag.
- Head refill: when (!rd_valid || accepted pop) and the RAM holds unread words, the head loads mem[rd_ptr], rd_ptr increments and rd_valid is set.
- When the head is popped and the RAM holds no unread words, rd_valid clears and rd_data holds its last value.
- Push and pop in the same cycle: level is unchanged. When full, the pop is accepted and the push is dropped, because wr_full is evaluated before the edge.
- Capacity is exactly DEPTH words, including the head register; level never exceeds DEPTH.
- almost_full and almost_empty are decoded combinationally from the registered level.
- flush: pointers, level and rd_valid clear on the edge. rd_data and the error flags are retained.
- flush has priority over wr_en and rd_en in the same cycle; both requests are discarded.
- Reset mid-operation discards all contents. RAM contents are not cleared.
- Reset values: rd_data 0, rd_valid 0, wr_full 0, level 0, almost_full 0, almost_empty 1, overflow 0, underflow 0.

## Timing
- Write-to-read latency into an empty FIFO:
  - Push accepted on edge N: level = 1 after edge N.
  - RAM read into the head register on edge N+1: rd_valid = 1 and rd_data = word after edge N+1.
- Sustained throughput is one push and one pop per cycle. With rd_en held high and data available, a new head appears every edge with no bubbles.
- wr_full, level and the almost flags reflect the state after the most recent edge. There is no look-ahead.
- Between an accepted push and its visibility at the head, level counts the word while rd_valid may still be 0 (the 1-cycle fall-through window).

## Configuration
- SYNC_FIFO_ERR_FLAGS_EN defined:
  - overflow sets on any push while wr_full.
  - underflow sets on any rd_en while !rd_valid.
  - Both are sticky and cleared only by reset (not by flush).
- Not defined: both ports are tied to 0 and no flag logic is built.

## Test plan
Parameters for all scenarios: DATA_WIDTH=8, ADDR_WIDTH=2 (DEPTH 4), AFULL_THRESH=3, AEMPTY_THRESH=1.
- Reset, then single push 0xA5 -> level 1 after push edge; rd_valid 1 and rd_data 0xA5 one edge later; pop -> rd_valid 0, level 0.
- Push 0x01..0x04 back-to-back, then push 0x05:
  - wr_full 1 and almost_full 1 at level 4.
  - 0x05 dropped; overflow 1 (macro on) or 0 (macro off).
  - Pops return 0x01..0x04 in order.
- Simultaneous push/pop at level 4 -> pop accepted, push dropped, level 3. At level 2 -> level stays 2 and order is preserved.
- Continuous push and pop with rd_en held high for 20 cycles -> rd_valid stays 1 after the first fill; every word arrives in order; pointers wrap twice with no loss.
- Fill to 3, assert flush together with wr_en=1 -> level 0, rd_valid 0, almost_empty 1, the write discarded. rd_en with rd_valid 0 -> underflow 1; reset clears it.
